mem_port_arbiter: RTL and testbench

- Sequences and shares one unified single-port memory between the instruction-fetch requester and the memory-stage load/store requester.
- Sits between IF/MEM stages and the memory model; replaces direct stage-to-memory wiring.
- Grants one requester at a time, holds its request stable on the memory port until the memory accepts it, then returns an ack/data pulse.
- Data side has priority, with a starvation guard so fetch cannot be locked out.

---
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the load/store stage.
// Data side has priority; a starvation counter forces fetch through after STARVE_LIMIT data grants.
//
// state | meaning
// IDLE  | memory port free, grant on any request
// BUSY  | latched request presented on mem_*, waiting for mem_ready
// RESP  | owner's ack pulses for this one cycle, no new grant
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  stall_fetch,
    output logic                  stall_mem
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    state_t                state_q,      state_d;
    owner_t                owner_q,      owner_d;
    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic                  mem_req_q,    mem_req_d;
    logic                  mem_we_q,     mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q,   if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q,   dm_rdata_d;
    logic                  if_ack_q,     if_ack_d;
    logic                  dm_ack_q,     dm_ack_d;

    logic fetch_starved;
    logic dm_win;
    logic if_win;

    // Fetch overrides data only once it has lost STARVE_LIMIT grants in a row.
    assign fetch_starved = if_req && (starve_cnt_q >= CNT_MAX);
    assign dm_win        = dm_req && !fetch_starved;
    assign if_win        = if_req && !dm_win;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dm_win) begin
                    state_d     = ST_BUSY;
                    owner_d     = OWN_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    if (if_req) begin
                        if (starve_cnt_q < CNT_MAX) begin
                            starve_cnt_d = starve_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        starve_cnt_d = '0;
                    end
                end else if (if_win) begin
                    state_d      = ST_BUSY;
                    owner_d      = OWN_IF;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = mem_wdata_q;
                    starve_cnt_d = '0;
                end
            end

            ST_BUSY: begin
                if (mem_ready) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (owner_q == OWN_DM) begin
                        dm_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IF;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign if_ack      = if_ack_q;
    assign dm_ack      = dm_ack_q;
    assign stall_fetch = if_req & ~if_ack_q;
    assign stall_mem   = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_fetch;
    logic        stall_mem;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ack     (if_ack),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_ack     (dm_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .stall_fetch(stall_fetch),
        .stall_mem  (stall_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = 32'h0;
        dm_wdata  = 32'h0;
        mem_rdata = 32'h0;
        mem_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_mem_req",  32'(mem_req),  32'h0);
        chk("rst_mem_we",   32'(mem_we),   32'h0);
        chk("rst_mem_addr", mem_addr,      32'h0);
        chk("rst_if_ack",   32'(if_ack),   32'h0);
        chk("rst_dm_ack",   32'(dm_ack),   32'h0);
        chk("rst_dm_rdata", dm_rdata,      32'h0);
        chk("rst_if_rdata", if_rdata,      32'h0);
        rst_n = 1'b1;
        step();

        // Reset asserted while BUSY abandons the access
        dm_req  = 1'b1;
        dm_addr = 32'h40;
        step();
        chk("rb_grant_req",  32'(mem_req), 32'h1);
        chk("rb_grant_addr", mem_addr,     32'h40);
        mem_ready = 1'b1;
        mem_rdata = 32'hAAAA_5555;
        rst_n     = 1'b0;
        #1;
        chk("rb_async_req",  32'(mem_req), 32'h0);
        chk("rb_async_addr", mem_addr,     32'h0);
        step();
        chk("rb_no_ack",   32'(dm_ack), 32'h0);
        chk("rb_rdata",    dm_rdata,    32'h0);
        dm_req    = 1'b0;
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        step();
        chk("rb_idle_req", 32'(mem_req), 32'h0);

        // Single load with two wait cycles
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h100;
        step();
        chk("ld_req_c1",   32'(mem_req),   32'h1);
        chk("ld_addr",     mem_addr,       32'h100);
        chk("ld_we",       32'(mem_we),    32'h0);
        chk("ld_stall_c1", 32'(stall_mem), 32'h1);
        step();
        chk("ld_req_c2",   32'(mem_req),   32'h1);
        chk("ld_ack_c2",   32'(dm_ack),    32'h0);
        step();
        chk("ld_req_c3",   32'(mem_req),   32'h1);
        chk("ld_stall_c3", 32'(stall_mem), 32'h1);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        chk("ld_ack",      32'(dm_ack),    32'h1);
        chk("ld_if_ack",   32'(if_ack),    32'h0);
        chk("ld_rdata",    dm_rdata,       32'hDEAD_BEEF);
        chk("ld_req_done", 32'(mem_req),   32'h0);
        chk("ld_stall_ack", 32'(stall_mem), 32'h0);
        dm_req    = 1'b0;
        mem_rdata = 32'h0BAD_F00D;
        step();
        chk("ld_ack_drop", 32'(dm_ack),  32'h0);
        chk("ld_hold",     dm_rdata,     32'hDEAD_BEEF);
        chk("ld_ign_rdy",  32'(mem_req), 32'h0);
        mem_ready = 1'b0;

        // Store completes immediately and leaves dm_rdata alone
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h200;
        dm_wdata = 32'h1234_5678;
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        step();
        chk("st_req",   32'(mem_req), 32'h1);
        chk("st_we",    32'(mem_we),  32'h1);
        chk("st_addr",  mem_addr,     32'h200);
        chk("st_wdata", mem_wdata,    32'h1234_5678);
        step();
        chk("st_ack",     32'(dm_ack), 32'h1);
        chk("st_we_clr",  32'(mem_we), 32'h0);
        chk("st_rdata",   dm_rdata,    32'hDEAD_BEEF);
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        mem_ready = 1'b0;
        step();
        chk("st_ack_drop", 32'(dm_ack), 32'h0);

        // Contention: data first, fetch after; then fetch held through its ack
        if_req  = 1'b1;
        if_addr = 32'h1000;
        dm_req  = 1'b1;
        dm_addr = 32'h300;
        step();
        chk("ct_dm_first", mem_addr,         32'h300);
        chk("ct_stall_if", 32'(stall_fetch), 32'h1);
        chk("ct_stall_dm", 32'(stall_mem),   32'h1);
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_1111;
        step();
        chk("ct_dm_ack",   32'(dm_ack),      32'h1);
        chk("ct_if_noack", 32'(if_ack),      32'h0);
        chk("ct_dm_rdata", dm_rdata,         32'h1111_1111);
        chk("ct_if_stall", 32'(stall_fetch), 32'h1);
        dm_req    = 1'b0;
        mem_ready = 1'b0;
        step();
        chk("ct_idle_req", 32'(mem_req), 32'h0);
        step();
        chk("ct_if_grant", mem_addr,     32'h1000);
        chk("ct_if_we",    32'(mem_we),  32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'h2222_2222;
        step();
        chk("ct_if_ack",    32'(if_ack),      32'h1);
        chk("ct_dm_noack",  32'(dm_ack),      32'h0);
        chk("ct_if_rdata",  if_rdata,         32'h2222_2222);
        chk("ct_if_unstall", 32'(stall_fetch), 32'h0);
        chk("ct_dm_keep",   dm_rdata,         32'h1111_1111);
        mem_ready = 1'b0;
        step();
        chk("hr_no_resp_grant", 32'(mem_req),      32'h0);
        chk("hr_ack_drop",      32'(if_ack),       32'h0);
        chk("hr_stall",         32'(stall_fetch),  32'h1);
        step();
        chk("hr_regrant_req",  32'(mem_req), 32'h1);
        chk("hr_regrant_addr", mem_addr,     32'h1000);
        mem_ready = 1'b1;
        mem_rdata = 32'h3333_3333;
        step();
        chk("hr_ack",   32'(if_ack), 32'h1);
        chk("hr_rdata", if_rdata,    32'h3333_3333);
        if_req    = 1'b0;
        mem_ready = 1'b0;
        step();

        // Starvation guard: four data grants while fetch waits, then fetch wins
        if_req  = 1'b1;
        if_addr = 32'h2000;
        dm_req  = 1'b1;
        dm_addr = 32'h400;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sv_dm_grant", mem_addr, 32'h400 + 32'(i));
            mem_ready = 1'b1;
            mem_rdata = 32'h5000_0000 + 32'(i);
            step();
            chk("sv_dm_ack",   32'(dm_ack), 32'h1);
            chk("sv_no_if",    32'(if_ack), 32'h0);
            chk("sv_dm_rdata", dm_rdata,    32'h5000_0000 + 32'(i));
            mem_ready = 1'b0;
            dm_addr   = 32'h400 + 32'(i + 1);
            step();
        end
        step();
        chk("sv_if_grant", mem_addr,    32'h2000);
        chk("sv_if_we",    32'(mem_we), 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'h6666_6666;
        step();
        chk("sv_if_ack",   32'(if_ack), 32'h1);
        chk("sv_dm_quiet", 32'(dm_ack), 32'h0);
        chk("sv_if_rdata", if_rdata,    32'h6666_6666);
        mem_ready = 1'b0;
        step();
        step();
        chk("sv_cnt_clear", mem_addr, 32'h404);
        mem_ready = 1'b1;
        mem_rdata = 32'h7777_7777;
        step();
        chk("sv_final_ack", 32'(dm_ack), 32'h1);
        if_req    = 1'b0;
        dm_req    = 1'b0;
        mem_ready = 1'b0;
        step();
        chk("end_idle", 32'(mem_req), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
